// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle; stalls HI/LO users while a result is pending.
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [5:0]            in_funct,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  output logic                  out_busy,
  output logic                  out_stall,
  output logic [DATA_WIDTH-1:0] out_hi,
  output logic [DATA_WIDTH-1:0] out_lo,
  output logic [DATA_WIDTH-1:0] out_mf_data,
  output logic                  out_mf_sel,
  output logic                  out_done
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         op_b;
  logic [2*W-1:0]       acc;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;

  logic f_mfhi, f_mthi, f_mflo, f_mtlo;
  logic f_mult, f_multu, f_div, f_divu;
  logic md_start, md_op;

  assign f_mfhi  = in_valid & (in_funct == 6'h10);
  assign f_mthi  = in_valid & (in_funct == 6'h11);
  assign f_mflo  = in_valid & (in_funct == 6'h12);
  assign f_mtlo  = in_valid & (in_funct == 6'h13);
  assign f_mult  = in_valid & (in_funct == 6'h18);
  assign f_multu = in_valid & (in_funct == 6'h19);
  assign f_div   = in_valid & (in_funct == 6'h1A);
  assign f_divu  = in_valid & (in_funct == 6'h1B);

  assign md_start = f_mult | f_multu | f_div | f_divu;
  assign md_op    = md_start | f_mfhi | f_mthi
                  | f_mflo | f_mtlo;

  assign out_stall  = out_busy & md_op;
  assign out_mf_sel = (f_mfhi | f_mflo) & ~out_stall;

  // Start-of-op operand conditioning: magnitudes plus sign flags.
  logic         sgn_op, rs_neg, rt_neg, dzero, start_div;
  logic [W-1:0] rs_abs, rt_abs;

  assign sgn_op    = f_mult | f_div;
  assign start_div = f_div | f_divu;
  assign dzero     = start_div & (in_rt_data == '0);
  assign rs_neg    = sgn_op & in_rs_data[W-1] & ~dzero;
  assign rt_neg    = sgn_op & in_rt_data[W-1] & ~dzero;
  assign rs_abs    = rs_neg ? -in_rs_data : in_rs_data;
  assign rt_abs    = rt_neg ? -in_rt_data : in_rt_data;

  // One iteration step for each operation kind.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_sh;
  logic           rem_ge;
  logic [W-1:0]   rem_new;
  logic [2*W-1:0] div_next;

  assign mul_sum  = {1'b0, acc[2*W-1:W]}
                  + {1'b0, acc[0] ? op_b : '0};
  assign mul_next = {mul_sum, acc[W-1:1]};

  assign rem_sh   = acc[2*W-1:W-1];
  assign rem_ge   = rem_sh >= {1'b0, op_b};
  assign rem_new  = rem_ge ? W'(rem_sh - {1'b0, op_b})
                           : rem_sh[W-1:0];
  assign div_next = {rem_new, acc[W-2:0], rem_ge};

  // Sign-corrected results written in FINISH.
  logic [2*W-1:0] mul_res;
  logic [W-1:0]   q_res, r_res;

  assign mul_res = neg_q ? -acc : acc;
  assign q_res   = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign r_res   = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  // MFHI/MFLO read port: registers only, no write bypass.
  always_comb begin
    out_mf_data = '0;
    unique case (1'b1)
      f_mfhi:  out_mf_data = out_hi;
      f_mflo:  out_mf_data = out_lo;
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (md_start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      out_busy <= 1'b0;
      out_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_busy <= (state_d != IDLE);
      out_done <= (state_q == FINISH);
    end
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_b   <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (md_start) begin
        cnt    <= '0;
        is_div <= start_div;
        neg_q  <= rs_neg ^ rt_neg;
        neg_r  <= rs_neg;
        op_b   <= start_div ? rt_abs : rs_abs;
        acc    <= {{W{1'b0}},
                   start_div ? rs_abs : rt_abs};
      end
    end else if (state_q == RUN) begin
      cnt <= cnt + CNT_WIDTH'(1);
      acc <= is_div ? div_next : mul_next;
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_hi <= '0;
      out_lo <= '0;
    end else if (state_q == FINISH) begin
      out_hi <= is_div ? r_res : mul_res[2*W-1:W];
      out_lo <= is_div ? q_res : mul_res[W-1:0];
    end else if (state_q == IDLE) begin
      if (f_mthi) out_hi <= in_rs_data;
      if (f_mtlo) out_lo <= in_rs_data;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized bench for ex_muldiv_unit.
// Compares HI/LO, timing and stall behaviour against an arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        out_busy;
  logic        out_stall;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic [31:0] out_mf_data;
  logic        out_mf_sel;
  logic        out_done;

  int unsigned n_pass;
  int unsigned n_total;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  ex_muldiv_unit dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_funct    (in_funct),
    .in_rs_data  (in_rs_data),
    .in_rt_data  (in_rt_data),
    .out_busy    (out_busy),
    .out_stall   (out_stall),
    .out_hi      (out_hi),
    .out_lo      (out_lo),
    .out_mf_data (out_mf_data),
    .out_mf_sel  (out_mf_sel),
    .out_done    (out_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  function automatic logic [63:0] model(
      input logic [5:0] f,
      input logic [31:0] a,
      input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (f)
      6'h18: res = 64'(sa * sb);
      6'h19: res = ua * ub;
      6'h1A, 6'h1B: begin
        if (b == 0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          if (f == 6'h1A) begin
            q = sa / sb;
            r = sa % sb;
            qv = 64'(q);
            rv = 64'(r);
          end else begin
            qv = ua / ub;
            rv = ua % ub;
          end
          res = {rv[31:0], qv[31:0]};
        end
      end
      default: res = {hi_m, lo_m};
    endcase
    return res;
  endfunction

  function automatic logic is_md(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
  endfunction

  task automatic drive(input logic v, input logic [5:0] f,
                       input logic [31:0] rs,
                       input logic [31:0] rt);
    in_valid   = v;
    in_funct   = f;
    in_rs_data = rs;
    in_rt_data = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div, feed unrelated traffic, check result/timing.
  task automatic run_md(input string tag,
                        input logic [5:0] f,
                        input logic [31:0] rs,
                        input logic [31:0] rt);
    logic [63:0] exp;
    logic [5:0]  ff;
    logic        fv;
    logic        stall_bad;
    int          busy_n, done_n;
    exp = model(f, rs, rt);
    drive(1'b1, f, rs, rt);
    tick();
    busy_n = 0;
    done_n = 0;
    stall_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_busy) busy_n++;
      if (out_done) done_n++;
      fv = ($urandom_range(0, 3) != 0);
      ff = 6'($urandom);
      if (is_md(ff)) ff = 6'h20;
      drive(fv, ff, $urandom, $urandom);
      #1;
      if (out_stall) stall_bad = 1'b1;
      tick();
    end
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    chk({tag, "_busy33"}, 64'(busy_n), 64'd33);
    chk({tag, "_done1"}, 64'(done_n), 64'd1);
    chk({tag, "_nostall"}, 64'(stall_bad), 64'd0);
    chk({tag, "_hi"}, 64'(out_hi), 64'(hi_m));
    chk({tag, "_lo"}, 64'(out_lo), 64'(lo_m));
  endtask

  task automatic mt_mf(input logic hi_sel,
                       input logic [31:0] val);
    drive(1'b1, hi_sel ? 6'h11 : 6'h13, val, $urandom);
    #1;
    chk("mt_nostall", 64'(out_stall), 64'd0);
    tick();
    if (hi_sel) hi_m = val;
    else lo_m = val;
    drive(1'b1, hi_sel ? 6'h10 : 6'h12, $urandom, $urandom);
    #1;
    chk("mf_sel", 64'(out_mf_sel), 64'd1);
    chk("mf_data", 64'(out_mf_data),
        64'(hi_sel ? hi_m : lo_m));
    chk("mf_nostall", 64'(out_stall), 64'd0);
    tick();
    drive(1'b0, 6'h00, 32'd0, 32'd0);
  endtask

  initial begin
    int          n;
    logic        sel_bad;
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    logic [5:0]  md_tab [4];
    n_pass  = 0;
    n_total = 0;
    hi_m = '0;
    lo_m = '0;
    md_tab[0] = 6'h18;
    md_tab[1] = 6'h19;
    md_tab[2] = 6'h1A;
    md_tab[3] = 6'h1B;
    reset = 1'b0;
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    #12;
    chk("rst_busy", 64'(out_busy), 64'd0);
    chk("rst_done", 64'(out_done), 64'd0);
    chk("rst_hi", 64'(out_hi), 64'd0);
    chk("rst_lo", 64'(out_lo), 64'd0);
    reset = 1'b1;
    tick();

    run_md("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_hi_k", 64'(out_hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo_k", 64'(out_lo), 64'hFFFF_FFEB);
    run_md("multu", 6'h19, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_k", 64'(out_hi), 64'h1);
    run_md("divu", 6'h1B, 32'd100, 32'd7);
    chk("divu_lo_k", 64'(out_lo), 64'd14);
    run_md("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo_k", 64'(out_lo), 64'hFFFF_FFFD);
    run_md("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_k", 64'(out_lo), 64'h8000_0000);
    run_md("divu_z", 6'h1B, 32'd5, 32'd0);
    chk("divu_z_hi_k", 64'(out_hi), 64'd5);
    run_md("div_z", 6'h1A, 32'hFFFF_FFF0, 32'd0);
    chk("div_z_lo_k", 64'(out_lo), 64'hFFFF_FFFF);

    // MULT then MFLO presented back-to-back.
    drive(1'b1, 6'h18, 32'd3, 32'd4);
    tick();
    drive(1'b1, 6'h12, 32'd0, 32'd0);
    #1;
    n = 0;
    sel_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!out_stall) break;
      if (out_mf_sel) sel_bad = 1'b1;
      n++;
      tick();
    end
    hi_m = 32'd0;
    lo_m = 32'd12;
    chk("stall33", 64'(n), 64'd33);
    chk("stall_nosel", 64'(sel_bad), 64'd0);
    chk("rel_sel", 64'(out_mf_sel), 64'd1);
    chk("rel_data", 64'(out_mf_data), 64'd12);
    tick();
    drive(1'b1, 6'h20, 32'd1, 32'd2);
    #1;
    chk("add_mfdata0", 64'(out_mf_data), 64'd0);
    chk("add_nosel", 64'(out_mf_sel), 64'd0);
    drive(1'b0, 6'h00, 32'd0, 32'd0);

    mt_mf(1'b1, 32'hDEAD_BEEF);
    mt_mf(1'b0, 32'h1234_5678);

    // in_valid=0 suppresses MT writes and op starts.
    drive(1'b0, 6'h11, 32'hCAFE_F00D, 32'd0);
    tick();
    drive(1'b0, 6'h18, 32'd9, 32'd9);
    tick();
    chk("inv_hi", 64'(out_hi), 64'(hi_m));
    chk("inv_busy", 64'(out_busy), 64'd0);
    drive(1'b0, 6'h00, 32'd0, 32'd0);

    for (int k = 0; k < 24; k++) begin
      rf = md_tab[$urandom_range(0, 3)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      run_md("rnd", rf, ra, rb);
      if ($urandom_range(0, 2) == 0)
        mt_mf($urandom_range(0, 1) == 1, $urandom);
    end

    // Reset in the middle of a divide.
    drive(1'b1, 6'h1A, 32'd1000, 32'd3);
    tick();
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(out_busy), 64'd0);
    chk("mid_rst_hi", 64'(out_hi), 64'd0);
    chk("mid_rst_lo", 64'(out_lo), 64'd0);
    #3;
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_done || out_busy) n++;
    end
    chk("mid_rst_quiet", 64'(n), 64'd0);
    chk("mid_rst_lo2", 64'(out_lo), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage multi-cycle multiply/divide unit with architectural HI/LO registers.
- Fed by the ID/EX pipeline outputs: funct, ReadData1 (rs value) and ReadData2 (rt value).
- Handles MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Drives a stall to the hazard logic while an iterative operation is in flight. Supplies MFHI/MFLO data to the EX result mux.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  ID/EX holds a valid R-type instruction; gates all funct decode
- in_funct  input  6  funct field from ID/EX
- in_rs_data  input  32  ID/EX ReadData1: dividend / multiplicand / MTxx source
- in_rt_data  input  32  ID/EX ReadData2: divisor / multiplier
- out_busy  output  1  registered; high while state is RUN or FINISH
- out_stall  output  1  combinational; freeze PC, IF/ID and ID/EX, insert bubble into EX/MEM
- out_hi  output  32  HI register
- out_lo  output  32  LO register
- out_mf_data  output  32  combinational; HI for MFHI, LO for MFLO, else 0
- out_mf_sel  output  1  combinational; in_valid & (MFHI|MFLO) & ~out_stall
- out_done  output  1  registered; one-cycle pulse on the edge HI/LO receive a mult/div result

Behaviour:
- Decode is valid only when in_valid=1:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - md_op = any of these eight
- Reset (reset=0, any time, including mid-operation): state=IDLE, HI=0, LO=0, counter=0, internal operand/accumulator regs=0, out_busy=0, out_done=0. Any in-flight result is discarded.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - MULT/MULTU/DIV/DIVU: latch operands and record signedness. Signed ops store absolute values plus a result-sign flag. Counter=0, go to RUN.
  - MTHI/MTLO: write HI or LO from in_rs_data on this edge; stay IDLE.
  - MFHI/MFLO: no state change.
- RUN: one radix-2 iteration per cycle, 32 cycles (counter 0..31). At counter=31 go to FINISH.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
- FINISH:
  - Apply sign correction and write HI/LO.
  - Assert out_done for the following cycle.
  - Return to IDLE.
- Latency: start edge at T, HI/LO valid after edge T+33, out_busy high for cycles T+1..T+33.
- Result rules:
  - Multiply: {HI,LO} = 64-bit product; MULT is two's-complement, MULTU is unsigned.
  - Divide: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - Divide by zero: LO=0xFFFFFFFF, HI=dividend (raw in_rs_data). Same latency; no exception.
  - Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- Stall: out_stall = out_busy & in_valid & md_op.
  - Non-HI/LO instructions flow through during RUN; they are not stalled.
  - A stalled instruction is held by upstream and re-evaluated each cycle; it issues in the cycle out_busy is low.
- A new mult/div cannot issue in the FINISH cycle; it is stalled one more cycle.
- in_valid=0: ignore all funct values; MTxx writes are suppressed.
- out_mf_data reads the HI/LO registers directly. There is no bypass of a same-cycle MTxx write; the next instruction sees the new value.
- Operands are latched at start, so ID/EX changes during RUN do not affect the result.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> out_busy high exactly 33 cycles, out_done pulse once, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=2 -> HI=0x00000001, LO=0xFFFFFFFE. DIVU 100/7 -> LO=14, HI=2.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5 after 33 cycles.
- MULT 3*4, then MFLO presented on the next cycle -> out_stall=1 for 33 cycles, out_mf_sel=0 while stalled. On release out_mf_sel=1, out_mf_data=12. An ADD (funct 0x20) during RUN -> out_stall=0.
- MTHI rs=0xDEADBEEF, then MFHI -> out_mf_data=0xDEADBEEF, no stall. DIV started then reset=0 at RUN cycle 10 -> immediate IDLE, HI=LO=0, out_busy=0, no out_done.
